// File: rtl/song_pkg.sv
// Shared definitions for the song memory: note codes, field widths, entry layout
// and recorder states. Imported by the recorder, study and playback models.
package song_pkg;

    localparam int unsigned NOTE_W = 3;
    localparam int unsigned DUR_W  = 5;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned SLOT_W = 3;
    localparam int unsigned LEN_W  = ADDR_W + 1;
    localparam int unsigned KEY_W  = 7;

    localparam logic [NOTE_W-1:0] REST = 3'd0;
    localparam logic [NOTE_W-1:0] DO   = 3'd1;
    localparam logic [NOTE_W-1:0] RE   = 3'd2;
    localparam logic [NOTE_W-1:0] MI   = 3'd3;
    localparam logic [NOTE_W-1:0] FA   = 3'd4;
    localparam logic [NOTE_W-1:0] SOL  = 3'd5;
    localparam logic [NOTE_W-1:0] LA   = 3'd6;
    localparam logic [NOTE_W-1:0] SI   = 3'd7;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  dur;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_KEY,
        HOLD,
        GAP
    } rec_state_t;

    // Lowest pressed key wins; no key pressed decodes to REST.
    function automatic logic [NOTE_W-1:0] decode_key(input logic [KEY_W-1:0] keys);
        logic [NOTE_W-1:0] code;
        code = REST;
        for (int i = KEY_W - 1; i >= 0; i--) begin
            if (keys[i]) code = NOTE_W'(i + 1);
        end
        return code;
    endfunction

endpackage

// File: rtl/song_mem.sv
// Song storage: SLOTS*DEPTH entries, one synchronous write port and one
// registered read port returning old data on a same-address collision.
module song_mem
    import song_pkg::*;
#(
    parameter int unsigned SLOTS = 8,
    parameter int unsigned DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [SLOT_W+ADDR_W-1:0] waddr,
    input  entry_t                   wdata,
    input  logic [SLOT_W+ADDR_W-1:0] raddr,
    output entry_t                   rdata
);

    localparam int unsigned WORDS = SLOTS * DEPTH;

    entry_t mem [WORDS];

    // Contents are never cleared; the per-slot length marks what is valid.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) rdata <= '0;
        else        rdata <= mem[raddr];
    end

endmodule

// File: rtl/song_recorder.sv
// Record-mode front end: turns live key presses into (note, duration) entries
// in the selected song slot and exposes a read port for replay.
module song_recorder
    import song_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 10_000_000,
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned SLOTS       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [KEY_W-1:0]  user_input,
    input  logic [SLOT_W-1:0] user_selection,
    input  logic              user_store,
    input  logic [SLOT_W-1:0] rd_slot,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [NOTE_W-1:0] rd_note,
    output logic [DUR_W-1:0]  rd_dur,
    output logic [LEN_W-1:0]  rd_len,
    output logic              busy,
    output logic              full,
    output logic [KEY_W-1:0]  leds,
    output logic [NOTE_W-1:0] num_note,
    output logic [LEN_W-1:0]  entry_cnt
);

    localparam int unsigned      TICK_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [DUR_W-1:0]  DUR_MAX   = '1;
    localparam logic [LEN_W-1:0]  LEN_FULL  = LEN_W'(DEPTH);

    rec_state_t        state_q, state_d;
    logic              store_q, rise, fall, wrap, start, wr_req, wr_en;
    logic              full_d, busy_d;
    logic [NOTE_W-1:0] code, cur_q, cur_d, num_d;
    logic [DUR_W-1:0]  dur_q, dur_d, dur_eff;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [LEN_W-1:0]  cnt_d;
    logic [KEY_W-1:0]  leds_d;
    logic [LEN_W-1:0]  len_q [SLOTS];
    entry_t            wr_data, rd_entry;

    assign code = decode_key(user_input);
    assign rise = user_store & ~store_q;
    assign fall = ~user_store & store_q;
    assign wrap = (tick_q == TICK_LAST);
    // Duration including the cycle now ending, so a change edge sees the full length.
    assign dur_eff = (wrap && dur_q != DUR_MAX) ? dur_q + 1'b1 : dur_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (rise) state_d = WAIT_KEY;
            WAIT_KEY: if (fall) state_d = IDLE;
                      else if (code != REST) state_d = HOLD;
            HOLD:     if (fall) state_d = IDLE;
                      else if (code != cur_q) state_d = (code != REST) ? HOLD : GAP;
            GAP:      if (fall) state_d = IDLE;
                      else if (code != REST) state_d = HOLD;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        cur_d   = cur_q;
        dur_d   = dur_q;
        tick_d  = tick_q;
        slot_d  = slot_q;
        start   = 1'b0;
        wr_req  = 1'b0;
        wr_data = '0;
        if (state_q == HOLD || state_q == GAP) begin
            tick_d = wrap ? '0 : tick_q + 1'b1;
            dur_d  = dur_eff;
        end
        case (state_q)
            IDLE: if (rise) begin
                start  = 1'b1;
                slot_d = user_selection;
            end
            WAIT_KEY: if (!fall && code != REST) begin
                cur_d  = code;
                dur_d  = '0;
                tick_d = '0;
            end
            HOLD: if (fall || code != cur_q) begin
                wr_req       = 1'b1;
                wr_data.note = cur_q;
                wr_data.dur  = (dur_eff == '0) ? DUR_W'(1) : dur_eff;
                if (!fall && code != REST) cur_d = code;
                dur_d  = '0;
                tick_d = '0;
            end
            GAP: if (!fall && code != REST) begin
                wr_req       = (dur_eff != '0);
                wr_data.note = REST;
                wr_data.dur  = dur_eff;
                cur_d        = code;
                dur_d        = '0;
                tick_d       = '0;
            end
            default: ;
        endcase
        wr_en  = wr_req && (entry_cnt != LEN_FULL);
        cnt_d  = start ? '0 : (wr_en ? entry_cnt + 1'b1 : entry_cnt);
        full_d = (cnt_d == LEN_FULL);
        busy_d = (state_d != IDLE);
        leds_d = (state_d == HOLD) ? KEY_W'(1) << (cur_d - 1'b1) : '0;
        num_d  = (state_d == HOLD) ? cur_d : REST;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            store_q   <= 1'b0;
            cur_q     <= REST;
            dur_q     <= '0;
            tick_q    <= '0;
            slot_q    <= '0;
            entry_cnt <= '0;
            full      <= 1'b0;
            busy      <= 1'b0;
            leds      <= '0;
            num_note  <= REST;
        end else begin
            store_q   <= user_store;
            cur_q     <= cur_d;
            dur_q     <= dur_d;
            tick_q    <= tick_d;
            slot_q    <= slot_d;
            entry_cnt <= cnt_d;
            full      <= full_d;
            busy      <= busy_d;
            leds      <= leds_d;
            num_note  <= num_d;
        end
    end

    // Per-slot committed lengths; the active slot tracks entry_cnt live.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(SLOTS); i++) len_q[i] <= '0;
        end else if (start) begin
            len_q[user_selection] <= '0;
        end else if (wr_en) begin
            len_q[slot_q] <= cnt_d;
        end
    end

    assign rd_len = len_q[rd_slot];

    song_mem #(
        .SLOTS (SLOTS),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en),
        .waddr ({slot_q, entry_cnt[ADDR_W-1:0]}),
        .wdata (wr_data),
        .raddr ({rd_slot, rd_addr}),
        .rdata (rd_entry)
    );

    assign rd_note = rd_entry.note;
    assign rd_dur  = rd_entry.dur;

endmodule

// File: tb/tb_song_recorder.sv
// Directed bench for song_recorder with a 4-cycle duration tick.
module tb_song_recorder;
    import song_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [KEY_W-1:0]  user_input;
    logic [SLOT_W-1:0] user_selection;
    logic              user_store;
    logic [SLOT_W-1:0] rd_slot;
    logic [ADDR_W-1:0] rd_addr;
    logic [NOTE_W-1:0] rd_note;
    logic [DUR_W-1:0]  rd_dur;
    logic [LEN_W-1:0]  rd_len;
    logic              busy, full;
    logic [KEY_W-1:0]  leds;
    logic [NOTE_W-1:0] num_note;
    logic [LEN_W-1:0]  entry_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    song_recorder #(.TICK_CYCLES(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .user_input     (user_input),
        .user_selection (user_selection),
        .user_store     (user_store),
        .rd_slot        (rd_slot),
        .rd_addr        (rd_addr),
        .rd_note        (rd_note),
        .rd_dur         (rd_dur),
        .rd_len         (rd_len),
        .busy           (busy),
        .full           (full),
        .leds           (leds),
        .num_note       (num_note),
        .entry_cnt      (entry_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd_entry(input string tag, input logic [SLOT_W-1:0] s,
                            input logic [ADDR_W-1:0] a, input int note, input int dur);
        rd_slot = s;
        rd_addr = a;
        cyc(1);
        check({tag, ".note"}, 32'(rd_note), 32'(note));
        check({tag, ".dur"},  32'(rd_dur),  32'(dur));
    endtask

    task automatic len_is(input string tag, input logic [SLOT_W-1:0] s, input int exp);
        rd_slot = s;
        #1;
        check(tag, 32'(rd_len), 32'(exp));
    endtask

    task automatic press(input logic [KEY_W-1:0] keys, input int n);
        user_input = keys;
        cyc(n);
    endtask

    initial begin
        rst_n = 1'b0; user_input = '0; user_selection = '0; user_store = 1'b0;
        rd_slot = '0; rd_addr = '0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);

        // Reset mid-stream after one entry landed in slot 7
        user_selection = 3'd7; user_store = 1'b1; cyc(1);
        press(7'h01, 5);
        press(7'h02, 3);
        check("pre_rst.busy", 32'(busy), 1);
        check("pre_rst.cnt", 32'(entry_cnt), 1);
        check("pre_rst.leds", 32'(leds), 32'h02);
        len_is("pre_rst.len7", 3'd7, 1);
        rst_n = 1'b0; user_store = 1'b0; user_input = '0;
        cyc(2);
        rst_n = 1'b1;
        check("rst.busy", 32'(busy), 0);
        check("rst.full", 32'(full), 0);
        check("rst.leds", 32'(leds), 0);
        check("rst.num_note", 32'(num_note), 0);
        check("rst.cnt", 32'(entry_cnt), 0);
        for (int s = 0; s < 8; s++) len_is($sformatf("rst.len%0d", s), 3'(s), 0);
        cyc(1);

        // Basic take into slot 2; selection change while busy is ignored
        user_selection = 3'd2; user_store = 1'b1; cyc(5);
        user_selection = 3'd5;
        press(7'h01, 12);
        press(7'h00, 8);
        press(7'h10, 4);
        user_store = 1'b0; press(7'h00, 2);
        check("basic.busy", 32'(busy), 0);
        len_is("basic.len2", 3'd2, 3);
        len_is("basic.len5", 3'd5, 0);
        rd_entry("basic.e0", 3'd2, 5'd0, 1, 3);
        rd_entry("basic.e1", 3'd2, 5'd1, 0, 2);
        rd_entry("basic.e2", 3'd2, 5'd2, 5, 1);

        // Legato with multi-key priority into slot 3
        user_selection = 3'd3; user_store = 1'b1; cyc(1);
        press(7'h01, 2);
        press(7'h49, 4);
        check("legato.num_note", 32'(num_note), 1);
        check("legato.leds1", 32'(leds), 32'h01);
        press(7'h01, 2);
        press(7'h02, 8);
        check("legato.leds2", 32'(leds), 32'h02);
        user_store = 1'b0; press(7'h00, 1);
        check("legato.cnt", 32'(entry_cnt), 2);
        len_is("legato.len3", 3'd3, 2);
        rd_entry("legato.e0", 3'd3, 5'd0, 1, 2);
        rd_entry("legato.e1", 3'd3, 5'd1, 2, 2);

        // Short gap dropped, long hold saturates, tap gets dur 1 (slot 4)
        user_selection = 3'd4; user_store = 1'b1; cyc(1);
        press(7'h04, 4);
        press(7'h00, 2);
        press(7'h08, 160);
        check("sat.num_note", 32'(num_note), 4);
        check("sat.leds", 32'(leds), 32'h08);
        press(7'h00, 4);
        press(7'h40, 1);
        press(7'h00, 1);
        user_store = 1'b0; cyc(1);
        len_is("sat.len4", 3'd4, 4);
        rd_entry("sat.e0", 3'd4, 5'd0, 3, 1);
        rd_entry("sat.e1", 3'd4, 5'd1, 4, 31);
        rd_entry("sat.e2", 3'd4, 5'd2, 0, 1);
        rd_entry("sat.e3", 3'd4, 5'd3, 7, 1);

        // Overflow of slot 6
        user_selection = 3'd6; user_store = 1'b1; cyc(1);
        for (int i = 0; i < 40; i++) begin
            press(7'h01, 4);
            press(7'h00, 4);
        end
        check("ovf.full", 32'(full), 1);
        check("ovf.cnt", 32'(entry_cnt), 32);
        check("ovf.busy", 32'(busy), 1);
        user_store = 1'b0; cyc(1);
        len_is("ovf.len6", 3'd6, 32);
        rd_entry("ovf.e0", 3'd6, 5'd0, 1, 1);
        rd_entry("ovf.e30", 3'd6, 5'd30, 1, 1);
        rd_entry("ovf.e31", 3'd6, 5'd31, 0, 1);

        // Slot 1 take, then reset during HOLD of a slot 5 take
        user_selection = 3'd1; user_store = 1'b1; cyc(1);
        check("restart.full", 32'(full), 0);
        press(7'h01, 4);
        user_store = 1'b0; press(7'h00, 1);
        len_is("s1.len1", 3'd1, 1);
        user_selection = 3'd5; user_store = 1'b1; cyc(1);
        press(7'h02, 3);
        check("s5.num_note", 32'(num_note), 2);
        rst_n = 1'b0; user_store = 1'b0; user_input = '0;
        cyc(2);
        rst_n = 1'b1;
        check("rst2.busy", 32'(busy), 0);
        check("rst2.leds", 32'(leds), 0);
        len_is("rst2.len1", 3'd1, 0);
        len_is("rst2.len5", 3'd5, 0);
        user_selection = 3'd1; user_store = 1'b1; cyc(1);
        press(7'h20, 8);
        user_store = 1'b0; press(7'h00, 1);
        check("retake.cnt", 32'(entry_cnt), 1);
        len_is("retake.len1", 3'd1, 1);
        rd_entry("retake.e0", 3'd1, 5'd0, 6, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
